// File: rtl/adder_32_if.sv
// Operand/result bundle for the 32-bit CLA adder.
// The master drives operands and carry-in, and the slave (the adder) returns results.
interface adder_32_if;
    logic        i_cIn_1;
    logic [31:0] i_adderOperand1_32;
    logic [31:0] i_adderOperand2_32;
    logic [31:0] o_adderSum_32;
    logic        o_cOut_1;
    logic        o_overflow_1;
    logic        o_zero_1;
    logic [31:0] o_sumReg_32;
    logic        o_cOutReg_1;
    logic        o_overflowReg_1;

    modport slave (
        input  i_cIn_1,
        input  i_adderOperand1_32,
        input  i_adderOperand2_32,
        output o_adderSum_32,
        output o_cOut_1,
        output o_overflow_1,
        output o_zero_1,
        output o_sumReg_32,
        output o_cOutReg_1,
        output o_overflowReg_1
    );

    modport master (
        output i_cIn_1,
        output i_adderOperand1_32,
        output i_adderOperand2_32,
        input  o_adderSum_32,
        input  o_cOut_1,
        input  o_overflow_1,
        input  o_zero_1,
        input  o_sumReg_32,
        input  o_cOutReg_1,
        input  o_overflowReg_1
    );
endinterface

// File: rtl/adder_32.sv
// 32-bit two-level carry-lookahead adder with a zero-latency result path
// and a one-cycle registered copy of the result and flags.
module adder_32 (
    input  logic        i_clk,
    input  logic        i_rst_n,
    adder_32_if.slave   bus
);

    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        carry_in;
    logic [31:0] bit_g;
    logic [31:0] bit_p;
    logic [31:0] bit_carry;
    logic [31:0] sum;
    logic [7:0]  grp_g;
    logic [7:0]  grp_p;
    logic [8:0]  grp_carry;

    assign op_a     = bus.i_adderOperand1_32;
    assign op_b     = bus.i_adderOperand2_32;
    assign carry_in = bus.i_cIn_1;

    assign bit_g = op_a & op_b;
    assign bit_p = op_a ^ op_b;

    // Flattened carry into group k+1. Every generate/propagate product is formed
    // independently, so no carry ripples from one group to the next.
    function automatic logic lookahead_carry(
        input logic [7:0] g,
        input logic [7:0] p,
        input logic       cin,
        input int         k
    );
        logic result;
        logic term;
        result = cin;
        for (int m = 0; m < 8; m++) begin
            if (m <= k) begin
                result = result & p[m];
            end
        end
        for (int j = 0; j < 8; j++) begin
            if (j <= k) begin
                term = g[j];
                for (int m = 0; m < 8; m++) begin
                    if ((m > j) && (m <= k)) begin
                        term = term & p[m];
                    end
                end
                result = result | term;
            end
        end
        return result;
    endfunction

    generate
        for (genvar grp = 0; grp < 8; grp++) begin : g_cla
            logic [3:0] g;
            logic [3:0] p;
            logic [3:0] c;

            assign g = bit_g[4*grp +: 4];
            assign p = bit_p[4*grp +: 4];

            assign c[0] = grp_carry[grp];
            assign c[1] = g[0]
                        | (p[0] & c[0]);
            assign c[2] = g[1]
                        | (p[1] & g[0])
                        | (p[1] & p[0] & c[0]);
            assign c[3] = g[2]
                        | (p[2] & g[1])
                        | (p[2] & p[1] & g[0])
                        | (p[2] & p[1] & p[0] & c[0]);

            assign grp_g[grp] = g[3]
                              | (p[3] & g[2])
                              | (p[3] & p[2] & g[1])
                              | (p[3] & p[2] & p[1] & g[0]);
            assign grp_p[grp] = &p;

            assign bit_carry[4*grp +: 4] = c;
            assign sum[4*grp +: 4]       = p ^ c;
        end
    endgenerate

    always_comb begin
        grp_carry    = '0;
        grp_carry[0] = carry_in;
        for (int k = 0; k < 8; k++) begin
            grp_carry[k+1] = lookahead_carry(grp_g, grp_p, carry_in, k);
        end
    end

    assign bus.o_adderSum_32 = sum;
    assign bus.o_cOut_1      = grp_carry[8];
    assign bus.o_overflow_1  = bit_carry[31] ^ grp_carry[8];
    assign bus.o_zero_1      = ~|sum;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            bus.o_sumReg_32     <= '0;
            bus.o_cOutReg_1     <= 1'b0;
            bus.o_overflowReg_1 <= 1'b0;
        end else begin
            bus.o_sumReg_32     <= sum;
            bus.o_cOutReg_1     <= grp_carry[8];
            bus.o_overflowReg_1 <= bit_carry[31] ^ grp_carry[8];
        end
    end

endmodule

// File: tb/tb_adder_32.sv
// Scoreboard bench for adder_32: stimulus queues expected results and
// a monitor compares them whenever a sample is announced.
module tb_adder_32;

    typedef struct {
        bit          is_reg;
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
        string       name;
    } exp_t;

    logic  clk = 1'b0;
    bit    clk_en = 1'b0;
    logic  rst_n = 1'b1;
    int    total = 0;
    int    bad = 0;
    exp_t  sb[$];
    event  sample_ev;

    adder_32_if bus_if();

    adder_32 dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus_if)
    );

    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    // Monitor: drains every queued expectation each time a sample is announced
    initial begin
        exp_t e;
        forever begin
            @(sample_ev);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                total++;
                if (e.is_reg) begin
                    if ({bus_if.o_sumReg_32, bus_if.o_cOutReg_1, bus_if.o_overflowReg_1} !==
                        {e.sum, e.cout, e.ovf}) begin
                        bad++;
                        $display("[TB] FAIL %s: got sum=%h cout=%b ovf=%b, want sum=%h cout=%b ovf=%b",
                                 e.name, bus_if.o_sumReg_32, bus_if.o_cOutReg_1,
                                 bus_if.o_overflowReg_1, e.sum, e.cout, e.ovf);
                    end
                end else begin
                    if ({bus_if.o_adderSum_32, bus_if.o_cOut_1, bus_if.o_overflow_1, bus_if.o_zero_1} !==
                        {e.sum, e.cout, e.ovf, e.zero}) begin
                        bad++;
                        $display("[TB] FAIL %s: got sum=%h cout=%b ovf=%b zero=%b, want sum=%h cout=%b ovf=%b zero=%b",
                                 e.name, bus_if.o_adderSum_32, bus_if.o_cOut_1, bus_if.o_overflow_1,
                                 bus_if.o_zero_1, e.sum, e.cout, e.ovf, e.zero);
                    end
                end
            end
        end
    end

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic cin);
        bus_if.i_adderOperand1_32 = a;
        bus_if.i_adderOperand2_32 = b;
        bus_if.i_cIn_1            = cin;
    endtask

    task automatic expect_comb(input logic [31:0] sum, input logic cout, input logic ovf,
                               input logic zero, input string name);
        exp_t e;
        e.is_reg = 1'b0; e.sum = sum; e.cout = cout; e.ovf = ovf; e.zero = zero; e.name = name;
        sb.push_back(e);
        -> sample_ev;
    endtask

    task automatic expect_reg(input logic [31:0] sum, input logic cout, input logic ovf,
                              input string name);
        exp_t e;
        e.is_reg = 1'b1; e.sum = sum; e.cout = cout; e.ovf = ovf; e.zero = 1'b0; e.name = name;
        sb.push_back(e);
        -> sample_ev;
    endtask

    task automatic apply_vec(input logic [31:0] a, input logic [31:0] b, input logic cin,
                             input logic [31:0] sum, input logic cout, input logic ovf,
                             input logic zero, input string name);
        drive(a, b, cin);
        #5;
        expect_comb(sum, cout, ovf, zero, name);
        #5;
    endtask

    initial begin
        logic [31:0] ra, rb, rs;
        logic        rc, ro, rco;
        logic [32:0] full;
        int          bad_before;

        drive('0, '0, 1'b0);

        apply_vec(32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1, "zero_add");
        apply_vec(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1, "full_wrap");
        apply_vec(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0, "pos_ovf");
        apply_vec(32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1, "neg_ovf");
        apply_vec(32'h0000_000F, 32'h0000_0001, 1'b0, 32'h0000_0010, 1'b0, 1'b0, 1'b0, "grp_boundary");
        apply_vec(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, "all_ones_cin");
        apply_vec(32'h1234_5678, 32'h1111_1111, 1'b1, 32'h2345_678A, 1'b0, 1'b0, 1'b0, "mixed");
        apply_vec(32'h0000_FFFF, 32'h0000_0000, 1'b1, 32'h0001_0000, 1'b0, 1'b0, 1'b0, "half_propagate");

        // Random vectors against a plain 33-bit golden sum, no clock running
        for (int i = 0; i < 100; i++) begin
            ra = $urandom;
            rb = $urandom;
            rc = 1'($urandom_range(1, 0));
            full = {1'b0, ra} + {1'b0, rb} + {32'b0, rc};
            rs  = full[31:0];
            rco = full[32];
            ro  = (ra[31] == rb[31]) && (rs[31] != ra[31]);
            bad_before = bad;
            apply_vec(ra, rb, rc, rs, rco, ro, (rs == 32'h0), "random");
            if (bad != bad_before) break;
        end

        rst_n = 1'b0;
        drive(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        clk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        expect_reg(32'h0, 1'b0, 1'b0, "reg_rst_hold");
        expect_comb(32'h8000_0000, 1'b0, 1'b1, 1'b0, "comb_in_reset");

        @(negedge clk);
        rst_n = 1'b1;
        drive(32'h1234_5678, 32'h1111_1111, 1'b1);
        @(posedge clk);
        #1;
        expect_reg(32'h2345_678A, 1'b0, 1'b0, "reg_load");

        @(negedge clk);
        drive(32'h8000_0000, 32'h8000_0000, 1'b0);
        @(posedge clk);
        #1;
        expect_reg(32'h0000_0000, 1'b1, 1'b1, "reg_ovf");

        @(negedge clk);
        rst_n = 1'b0;
        drive(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        @(posedge clk);
        #1;
        expect_reg(32'h0, 1'b0, 1'b0, "reg_mid_rst");
        expect_comb(32'h8000_0000, 1'b0, 1'b1, 1'b0, "comb_mid_rst");

        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        expect_reg(32'h8000_0000, 1'b0, 1'b1, "reg_reload");

        #5;
        clk_en = 1'b0;
        if (sb.size() != 0) begin
            bad++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/adder_32.md
Name: adder_32

Overview:
- 32-bit binary adder with carry-in and carry-out, used as the core arithmetic element of the RV32I datapath (ALU add, address/branch-target adds).
- Primary sum and carry path is purely combinational, with zero latency.
- A registered copy of the result and flags is provided for pipelined consumers; only this copy uses the clock and reset.

Parameters:
- none (width fixed at 32)

Ports:
- i_clk  input  1  clock; rising-edge active; drives the registered outputs only
- i_rst_n  input  1  synchronous active-low reset; clears the registered outputs only
- i_cIn_1  input  1  carry-in, added at bit 0
- i_adderOperand1_32  input  32  operand A, unsigned/two's-complement agnostic
- i_adderOperand2_32  input  32  operand B
- o_adderSum_32  output  32  combinational sum bits [31:0]
- o_cOut_1  output  1  combinational carry-out of bit 31
- o_overflow_1  output  1  combinational signed overflow
- o_zero_1  output  1  combinational: high when o_adderSum_32 == 0
- o_sumReg_32  output  32  registered o_adderSum_32
- o_cOutReg_1  output  1  registered o_cOut_1
- o_overflowReg_1  output  1  registered o_overflow_1

Behaviour:
- Arithmetic: {o_cOut_1, o_adderSum_32} = A + B + cIn, computed at 33-bit width with no truncation before bit 32.
- Combinational outputs:
  - Settle within the same delta/cycle as any input change.
  - Independent of i_clk and i_rst_n; valid during reset.
  - Must be correct with no clock edges at all.
- Overflow: o_overflow_1 = carry into bit 31 XOR carry out of bit 31 (equivalently, A[31]==B[31] and sum[31]!=A[31]).
- Zero: o_zero_1 = ~|o_adderSum_32.
- Structure:
  - Carry-lookahead: eight 4-bit CLA groups, each producing per-bit g=A&B, p=A^B, group G/P.
  - A second-level lookahead unit computes group carries c4, c8, ..., c32 from the group G/P and cIn.
  - sum[i] = p[i] ^ c[i].
  - No ripple chain longer than 4 bits.
- Registered outputs, updated on the rising edge of i_clk:
  - If i_rst_n==0: o_sumReg_32=0, o_cOutReg_1=0, o_overflowReg_1=0.
  - Else each register loads its combinational counterpart. Latency 1 cycle; no enable.
- Reset mid-operation: the combinational path is unaffected; the registers clear on the first edge with i_rst_n low and reload on the first edge after release.
- Boundary cases:
  - A=B=0xFFFFFFFF, cIn=1 -> sum 0xFFFFFFFF, cout 1.
  - Full wrap (0xFFFFFFFF+0+1) -> sum 0, cout 1, zero 1.
- No X propagation from registers after reset; outputs are defined for all 2^65 input combinations.

Test Plan:
- A=0x00000000, B=0x00000000, cIn=0 -> sum 0x00000000, cout 0, zero 1, ovf 0.
- A=0xFFFFFFFF, B=0x00000000, cIn=1 -> sum 0x00000000, cout 1, zero 1, ovf 0 (full carry propagate through all CLA groups).
- A=0x7FFFFFFF, B=0x00000001, cIn=0 -> sum 0x80000000, cout 0, ovf 1; A=0x80000000, B=0x80000000 -> sum 0, cout 1, ovf 1.
- A=0x0000000F, B=0x00000001, cIn=0 -> sum 0x00000010 (group-boundary carry); A=0xFFFFFFFF, B=0xFFFFFFFF, cIn=1 -> sum 0xFFFFFFFF, cout 1.
- 100 random {cIn, A, B} vectors, applied 10 time units apart with no clock -> combinational {cout, sum} equals the 33-bit golden A+B+cIn on every vector; stop at the first mismatch.
- Clocked check: hold i_rst_n=0 for 2 edges -> all Reg outputs 0 regardless of inputs; release, apply A=0x12345678, B=0x11111111, cIn=1 -> after 1 edge o_sumReg_32=0x2345678A, o_cOutReg_1=0; assert reset mid-stream -> registers 0 on the next edge.
